// File: rtl/jpeg_pkg.sv
// Shared constants, FSM encoding and helpers for the JPEG front-end blocks.
// The colour-space converter is the first consumer.
package jpeg_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } csc_state_e;

    // BT.601 full-range coefficients scaled by 256
    localparam int COEF_Y_R  = 77;
    localparam int COEF_Y_G  = 150;
    localparam int COEF_Y_B  = 29;
    localparam int COEF_CB_R = -43;
    localparam int COEF_CB_G = -85;
    localparam int COEF_CB_B = 128;
    localparam int COEF_CR_R = 128;
    localparam int COEF_CR_G = -107;
    localparam int COEF_CR_B = -21;

    localparam int ROUND_C    = 128;
    localparam int CHROMA_OFF = 128;

    function automatic logic [7:0] clamp_u8(input logic signed [11:0] v);
        logic [7:0] r;
        if (v < 12'sd0) begin
            r = 8'd0;
        end else if (v > 12'sd255) begin
            r = 8'd255;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rgb_to_ycbcr_if.sv
// Pixel stream bundle around rgb_to_ycbcr: RGB in, YCbCr out, plus frame tags.
// Handshake: a beat transfers on every rising edge where valid is high; there is
// no ready, so the consumer must take every valid beat.
interface rgb_to_ycbcr_if;
    logic       start;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       valid_in;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       valid_out;
    logic       start_out;
    logic       frame_done;

    modport master (
        output start, r, g, b, valid_in,
        input  y, cb, cr, valid_out, start_out, frame_done
    );

    modport slave (
        input  start, r, g, b, valid_in,
        output y, cb, cr, valid_out, start_out, frame_done
    );
endinterface

// File: rtl/csc_mac3.sv
// One colour channel: three signed products (stage 1), then sum, round and
// floor-shift by 8 (stage 2). The result is a signed pre-offset channel value.
module csc_mac3 #(
    parameter int C0 = 0,
    parameter int C1 = 0,
    parameter int C2 = 0
) (
    input  logic               clk,
    input  logic [7:0]         a_i,
    input  logic [7:0]         b_i,
    input  logic [7:0]         c_i,
    output logic signed [11:0] res_o
);
    import jpeg_pkg::*;

    localparam logic signed [17:0] K0 = 18'(C0);
    localparam logic signed [17:0] K1 = 18'(C1);
    localparam logic signed [17:0] K2 = 18'(C2);
    localparam logic signed [18:0] RND = 19'(ROUND_C);

    logic signed [17:0] p0_d, p1_d, p2_d;
    logic signed [17:0] p0_q, p1_q, p2_q;
    logic signed [18:0] sum_d;
    logic signed [11:0] res_d, res_q;

    always_comb begin
        p0_d  = 18'($signed({1'b0, a_i})) * K0;
        p1_d  = 18'($signed({1'b0, b_i})) * K1;
        p2_d  = 18'($signed({1'b0, c_i})) * K2;
        sum_d = 19'(p0_q) + 19'(p1_q) + 19'(p2_q) + RND;
        res_d = 12'(sum_d >>> 8);
    end

    // Data path is left unreset; the valid bits in the top qualify it.
    always_ff @(posedge clk) begin
        p0_q  <= p0_d;
        p1_q  <= p1_d;
        p2_q  <= p2_d;
        res_q <= res_d;
    end

    assign res_o = res_q;
endmodule

// File: rtl/rgb_to_ycbcr.sv
// RGB to YCbCr converter with frame tracking: 3-stage pipeline (multiply,
// sum+round, offset+clamp) with SOF/EOF tags riding alongside each pixel.
module rgb_to_ycbcr
    import jpeg_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    input  logic       valid_in,
    output logic [7:0] y_out,
    output logic [7:0] cb_out,
    output logic [7:0] cr_out,
    output logic       valid_out,
    output logic       start_out,
    output logic       frame_done,
    output csc_state_e state_dbg
);
    localparam int          NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [16:0] LAST = 17'(NPIX - 1);
    localparam logic signed [11:0] OFF = 12'(CHROMA_OFF);

    csc_state_e  state_d, state_q;
    logic [16:0] cnt_d, cnt_q;
    logic        acc, sof, eof;

    logic v1_d, s1_d, e1_d, v1_q, s1_q, e1_q;
    logic v2_d, s2_d, e2_d, v2_q, s2_q, e2_q;
    logic [7:0] y_d, cb_d, cr_d, y_q, cb_q, cr_q;
    logic vo_d, so_d, fd_d, vo_q, so_q, fd_q;

    logic signed [11:0] y_res, cb_res, cr_res;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc     = 1'b0;
        sof     = 1'b0;
        eof     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_in && start) begin
                    acc = 1'b1;
                    sof = 1'b1;
                    // A 1-pixel frame opens and closes on the same beat
                    if (NPIX == 1) begin
                        eof = 1'b1;
                    end else begin
                        cnt_d   = 17'd1;
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (valid_in) begin
                    acc = 1'b1;
                    if (cnt_q == LAST) begin
                        eof     = 1'b1;
                        cnt_d   = 17'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 17'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        v1_d = acc;
        s1_d = sof;
        e1_d = eof;
        v2_d = v1_q;
        s2_d = s1_q;
        e2_d = e1_q;
        vo_d = v2_q;
        so_d = v2_q & s2_q;
        fd_d = v2_q & e2_q;
        y_d  = y_q;
        cb_d = cb_q;
        cr_d = cr_q;
        if (v2_q) begin
            y_d  = clamp_u8(y_res);
            cb_d = clamp_u8(cb_res + OFF);
            cr_d = clamp_u8(cr_res + OFF);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 17'd0;
            v1_q    <= 1'b0;
            s1_q    <= 1'b0;
            e1_q    <= 1'b0;
            v2_q    <= 1'b0;
            s2_q    <= 1'b0;
            e2_q    <= 1'b0;
            vo_q    <= 1'b0;
            so_q    <= 1'b0;
            fd_q    <= 1'b0;
            y_q     <= 8'd0;
            cb_q    <= 8'd0;
            cr_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v1_q    <= v1_d;
            s1_q    <= s1_d;
            e1_q    <= e1_d;
            v2_q    <= v2_d;
            s2_q    <= s2_d;
            e2_q    <= e2_d;
            vo_q    <= vo_d;
            so_q    <= so_d;
            fd_q    <= fd_d;
            y_q     <= y_d;
            cb_q    <= cb_d;
            cr_q    <= cr_d;
        end
    end

    csc_mac3 #(.C0(COEF_Y_R), .C1(COEF_Y_G), .C2(COEF_Y_B)) u_mac_y (
        .clk(clk), .a_i(r_in), .b_i(g_in), .c_i(b_in), .res_o(y_res)
    );
    csc_mac3 #(.C0(COEF_CB_R), .C1(COEF_CB_G), .C2(COEF_CB_B)) u_mac_cb (
        .clk(clk), .a_i(r_in), .b_i(g_in), .c_i(b_in), .res_o(cb_res)
    );
    csc_mac3 #(.C0(COEF_CR_R), .C1(COEF_CR_G), .C2(COEF_CR_B)) u_mac_cr (
        .clk(clk), .a_i(r_in), .b_i(g_in), .c_i(b_in), .res_o(cr_res)
    );

    assign y_out      = y_q;
    assign cb_out     = cb_q;
    assign cr_out     = cr_q;
    assign valid_out  = vo_q;
    assign start_out  = so_q;
    assign frame_done = fd_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// Directed bench for rgb_to_ycbcr: colour vectors, latency, hold, reset,
// a full 64x64 frame with gaps plus back-to-back start, and a 1x1 frame.
module tb_rgb_to_ycbcr;
  import jpeg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb_to_ycbcr_if bus0();
  rgb_to_ycbcr_if bus1();
  csc_state_e st0, st1;

  rgb_to_ycbcr #(.IMG_WIDTH(64), .IMG_HEIGHT(64)) u_dut (
    .clk(clk), .rst(rst), .start(bus0.start),
    .r_in(bus0.r), .g_in(bus0.g), .b_in(bus0.b), .valid_in(bus0.valid_in),
    .y_out(bus0.y), .cb_out(bus0.cb), .cr_out(bus0.cr),
    .valid_out(bus0.valid_out), .start_out(bus0.start_out),
    .frame_done(bus0.frame_done), .state_dbg(st0)
  );

  rgb_to_ycbcr #(.IMG_WIDTH(1), .IMG_HEIGHT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(bus1.start),
    .r_in(bus1.r), .g_in(bus1.g), .b_in(bus1.b), .valid_in(bus1.valid_in),
    .y_out(bus1.y), .cb_out(bus1.cb), .cr_out(bus1.cr),
    .valid_out(bus1.valid_out), .start_out(bus1.start_out),
    .frame_done(bus1.frame_done), .state_dbg(st1)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned cyc    = 0;
  int unsigned out_cnt = 0;
  logic        mon_en = 1'b0;
  // {expected cycle[31:0], y, cb, cr, sof, eof}
  logic [57:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b);
    bus0.start    = s;
    bus0.valid_in = v;
    bus0.r        = r;
    bus0.g        = g;
    bus0.b        = b;
  endtask

  function automatic logic [7:0] sat(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  function automatic logic [23:0] model(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
    int ri, gi, bi, y, cb, cr;
    ri = int'(r);
    gi = int'(g);
    bi = int'(b);
    y  = (77 * ri + 150 * gi + 29 * bi + 128) >>> 8;
    cb = ((-43 * ri - 85 * gi + 128 * bi + 128) >>> 8) + 128;
    cr = ((128 * ri - 107 * gi - 21 * bi + 128) >>> 8) + 128;
    return {sat(y), sat(cb), sat(cr)};
  endfunction

  // Directed pixel: accept, confirm nothing at 2 edges, data at 3, hold after.
  task automatic vec(input string tag, input logic s, input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b, input logic [23:0] exp, input logic exp_sof);
    drive(s, 1'b1, r, g, b);
    tick();
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    tick();
    check({tag, "_latency"}, 32'(bus0.valid_out), 32'd0);
    tick();
    check(tag, {8'd0, bus0.y, bus0.cb, bus0.cr}, {8'd0, exp});
    check({tag, "_tags"}, {29'd0, bus0.valid_out, bus0.start_out, bus0.frame_done},
          {29'd0, 1'b1, exp_sof, 1'b0});
    tick();
    check({tag, "_hold"}, {7'd0, bus0.valid_out, bus0.y, bus0.cb, bus0.cr}, {7'd0, 1'b0, exp});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus0.valid_out) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(bus0.valid_out), 32'd0);
        end else begin
          logic [57:0] e;
          e = exp_q.pop_front();
          check("frame_cycle", cyc, e[57:26]);
          check("frame_pix", {8'd0, bus0.y, bus0.cb, bus0.cr}, {8'd0, e[25:2]});
          check("frame_tags", {30'd0, bus0.start_out, bus0.frame_done}, {30'd0, e[1:0]});
        end
      end else begin
        check("gap_tags", {30'd0, bus0.start_out, bus0.frame_done}, 32'd0);
      end
    end
  end

  initial begin
    logic [7:0] r, g, b;
    logic       s;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    bus1.start = 1'b0; bus1.valid_in = 1'b0;
    bus1.r = 8'd0; bus1.g = 8'd0; bus1.b = 8'd0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_data", {8'd0, bus0.y, bus0.cb, bus0.cr}, 32'd0);
    check("rst_flags", {29'd0, bus0.valid_out, bus0.start_out, bus0.frame_done}, 32'd0);
    check("rst_state", 32'(st0), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Pixel with no start in IDLE is dropped
    drive(1'b0, 1'b1, 8'd200, 8'd10, 8'd30);
    tick();
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      check("nostart_valid", 32'(bus0.valid_out), 32'd0);
      tick();
    end
    check("nostart_state", 32'(st0), 32'(ST_IDLE));

    // Directed colour vectors: pixels 0..5 of a frame
    vec("white", 1'b1, 8'd255, 8'd255, 8'd255, {8'd255, 8'd128, 8'd128}, 1'b1);
    check("active_state", 32'(st0), 32'(ST_ACTIVE));
    vec("black", 1'b0, 8'd0,   8'd0,   8'd0,   {8'd0,   8'd128, 8'd128}, 1'b0);
    vec("red",   1'b0, 8'd255, 8'd0,   8'd0,   {8'd77,  8'd85,  8'd255}, 1'b0);
    vec("blue",  1'b0, 8'd0,   8'd0,   8'd255, {8'd29,  8'd255, 8'd107}, 1'b0);
    vec("green", 1'b1, 8'd0,   8'd255, 8'd0,   {8'd149, 8'd43,  8'd21},  1'b0);

    // Run to pixel 100 then reset together with a start request
    for (int i = 5; i < 100; i++) begin
      drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)));
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'd255, 8'd255, 8'd255);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    check("midrst_data", {8'd0, bus0.y, bus0.cb, bus0.cr}, 32'd0);
    check("midrst_state", 32'(st0), 32'(ST_IDLE));
    for (int i = 0; i < 3; i++) begin
      check("midrst_flags", {29'd0, bus0.valid_out, bus0.start_out, bus0.frame_done}, 32'd0);
      tick();
    end
    drive(1'b0, 1'b1, 8'd1, 8'd2, 8'd3);
    tick();
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      check("postrst_nostart", 32'(bus0.valid_out), 32'd0);
      tick();
    end

    // Full 64x64 frame with random gaps and stray starts, then frame 2 back-to-back
    mon_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        repeat ($urandom_range(1, 3)) tick();
      end
      r = 8'($urandom_range(0, 255));
      g = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      s = (i == 0) ? 1'b1 : ($urandom_range(0, 15) == 0);
      drive(s, 1'b1, r, g, b);
      exp_q.push_back({cyc + 32'd3, model(r, g, b), (i == 0), (i == 4095)});
      tick();
    end
    check("eof_state", 32'(st0), 32'(ST_IDLE));
    drive(1'b1, 1'b1, 8'd10, 8'd20, 8'd30);
    exp_q.push_back({cyc + 32'd3, model(8'd10, 8'd20, 8'd30), 1'b1, 1'b0});
    tick();
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    check("frame2_state", 32'(st0), 32'(ST_ACTIVE));
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
    check("frame_drain", exp_q.size(), 32'd0);
    check("frame_out_cnt", out_cnt, 32'd4097);
    mon_en = 1'b0;

    // 1x1 frame: every pixel is both SOF and EOF, back-to-back
    bus1.start = 1'b1; bus1.valid_in = 1'b1;
    bus1.r = 8'd255; bus1.g = 8'd0; bus1.b = 8'd0;
    tick();
    bus1.r = 8'd0; bus1.g = 8'd0; bus1.b = 8'd255;
    tick();
    bus1.start = 1'b0; bus1.valid_in = 1'b0;
    tick();
    check("px1_a_data", {8'd0, bus1.y, bus1.cb, bus1.cr}, {8'd0, 8'd77, 8'd85, 8'd255});
    check("px1_a_tags", {29'd0, bus1.valid_out, bus1.start_out, bus1.frame_done}, 32'd7);
    tick();
    check("px1_b_data", {8'd0, bus1.y, bus1.cb, bus1.cr}, {8'd0, 8'd29, 8'd255, 8'd107});
    check("px1_b_tags", {29'd0, bus1.valid_out, bus1.start_out, bus1.frame_done}, 32'd7);
    check("px1_state", 32'(st1), 32'(ST_IDLE));
    tick();
    check("px1_after", {29'd0, bus1.valid_out, bus1.start_out, bus1.frame_done}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
